multi_ch_lockin: RTL and testbench

- Parametrised N-channel dual-phase lock-in core; successor to the per-channel X/Y processing wrapper.
- Each channel multiplies its ADC sample by shared sine and cosine references (X and Y), then integrates and dumps over a programmable period.
- Outputs are scaled and saturated, with a valid strobe.
- Sits between the ADC/reference NCO front end and the PID/locking logic.

---
 rtl/multi_ch_lockin.sv | 175 +++++++++++++++++
 tb/tb_multi_ch_lockin.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multi_ch_lockin.sv
// N-channel dual-phase lock-in: per-channel X/Y products of the ADC sample with shared
// sin/cos references, integrate-and-dump over a programmable period, scaled and saturated.
module multi_ch_lockin #(
  parameter int N_CH  = 2,
  parameter int SIG_W = 14,
  parameter int REF_W = 16,
  parameter int OUT_W = 24,
  parameter int ACC_W = 56
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  input  logic [N_CH*SIG_W-1:0]   signal_in,
  input  logic [REF_W-1:0]        ref_sin,
  input  logic [REF_W-1:0]        ref_cos,
  input  logic [31:0]             period_len,
  input  logic [5:0]              shift,
  input  logic                    clear,
  output logic [N_CH*OUT_W-1:0]   x_out,
  output logic [N_CH*OUT_W-1:0]   y_out,
  output logic                    out_valid,
  output logic [2*N_CH-1:0]       sat
);

  localparam int PROD_W = SIG_W + REF_W;
  localparam logic signed [ACC_W-1:0] OUT_MAX = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] OUT_MIN = {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  logic [31:0]                cnt_q, cnt_d, per_q, per_d;
  logic                       last_d;

  logic                       s1_valid_q, s1_last_q;
  logic signed [SIG_W-1:0]    s1_sig_q [N_CH];
  logic signed [REF_W-1:0]    s1_sin_q, s1_cos_q;

  logic                       s2_valid_q, s2_last_q;
  logic signed [PROD_W-1:0]   s2_px_q [N_CH];
  logic signed [PROD_W-1:0]   s2_py_q [N_CH];

  logic signed [ACC_W-1:0]    acc_x_q [N_CH];
  logic signed [ACC_W-1:0]    acc_y_q [N_CH];
  logic signed [ACC_W-1:0]    sum_x_d [N_CH];
  logic signed [ACC_W-1:0]    sum_y_d [N_CH];
  logic signed [ACC_W-1:0]    res_x_q [N_CH];
  logic signed [ACC_W-1:0]    res_y_q [N_CH];
  logic                       res_valid_q;

  logic [N_CH*OUT_W-1:0]      x_q, y_q, x_d, y_d;
  logic [2*N_CH-1:0]          sat_q, sat_d;
  logic                       out_valid_q;

  // Result scaling: arithmetic shift then clamp; MSB of the return value is the saturation flag.
  function automatic logic [OUT_W:0] scale(input logic signed [ACC_W-1:0] v, input logic [5:0] sh);
    logic signed [ACC_W-1:0] r;
    r = v >>> sh;
    if (r > OUT_MAX)      scale = {1'b1, OUT_MAX[OUT_W-1:0]};
    else if (r < OUT_MIN) scale = {1'b1, OUT_MIN[OUT_W-1:0]};
    else                  scale = {1'b0, r[OUT_W-1:0]};
  endfunction

  // The period length is only sampled at the first sample of a period.
  always_comb begin
    per_d = per_q;
    if (cnt_q == 32'd0) per_d = (period_len == 32'd0) ? 32'd1 : period_len;
    last_d = (cnt_q == per_d - 32'd1);
    cnt_d  = last_d ? 32'd0 : cnt_q + 32'd1;
  end

  always_comb begin
    for (int i = 0; i < N_CH; i++) begin
      sum_x_d[i] = acc_x_q[i] + {{(ACC_W-PROD_W){s2_px_q[i][PROD_W-1]}}, s2_px_q[i]};
      sum_y_d[i] = acc_y_q[i] + {{(ACC_W-PROD_W){s2_py_q[i][PROD_W-1]}}, s2_py_q[i]};
    end
  end

  always_comb begin
    x_d   = '0;
    y_d   = '0;
    sat_d = '0;
    for (int i = 0; i < N_CH; i++) begin
      {sat_d[2*i],   x_d[i*OUT_W +: OUT_W]} = scale(res_x_q[i], shift);
      {sat_d[2*i+1], y_d[i*OUT_W +: OUT_W]} = scale(res_y_q[i], shift);
    end
  end

  // NOTE: all state updates use non-blocking assignments so every stage reads the previous
  // cycle's values of the stage before it, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q       <= '0;
      per_q       <= '0;
      s1_valid_q  <= 1'b0;
      s1_last_q   <= 1'b0;
      s1_sin_q    <= '0;
      s1_cos_q    <= '0;
      s2_valid_q  <= 1'b0;
      s2_last_q   <= 1'b0;
      res_valid_q <= 1'b0;
      out_valid_q <= 1'b0;
      x_q         <= '0;
      y_q         <= '0;
      sat_q       <= '0;
      // NOTE: the per-channel arrays are small register banks, not RAMs, so they are reset
      // element by element like any other flop.
      for (int i = 0; i < N_CH; i++) begin
        s1_sig_q[i] <= '0;
        s2_px_q[i]  <= '0;
        s2_py_q[i]  <= '0;
        acc_x_q[i]  <= '0;
        acc_y_q[i]  <= '0;
        res_x_q[i]  <= '0;
        res_y_q[i]  <= '0;
      end
    end else if (clear) begin
      cnt_q       <= '0;
      s1_valid_q  <= 1'b0;
      s1_last_q   <= 1'b0;
      s2_valid_q  <= 1'b0;
      s2_last_q   <= 1'b0;
      res_valid_q <= 1'b0;
      out_valid_q <= 1'b0;
      for (int i = 0; i < N_CH; i++) begin
        acc_x_q[i] <= '0;
        acc_y_q[i] <= '0;
      end
    end else begin
      s1_valid_q <= in_valid;
      s1_last_q  <= in_valid & last_d;
      if (in_valid) begin
        cnt_q    <= cnt_d;
        per_q    <= per_d;
        s1_sin_q <= ref_sin;
        s1_cos_q <= ref_cos;
        for (int i = 0; i < N_CH; i++) s1_sig_q[i] <= signal_in[i*SIG_W +: SIG_W];
      end

      s2_valid_q <= s1_valid_q;
      s2_last_q  <= s1_last_q;
      if (s1_valid_q) begin
        for (int i = 0; i < N_CH; i++) begin
          s2_px_q[i] <= s1_sig_q[i] * s1_sin_q;
          s2_py_q[i] <= s1_sig_q[i] * s1_cos_q;
        end
      end

      res_valid_q <= s2_valid_q & s2_last_q;
      if (s2_valid_q) begin
        for (int i = 0; i < N_CH; i++) begin
          if (s2_last_q) begin
            res_x_q[i] <= sum_x_d[i];
            res_y_q[i] <= sum_y_d[i];
            acc_x_q[i] <= '0;
            acc_y_q[i] <= '0;
          end else begin
            acc_x_q[i] <= sum_x_d[i];
            acc_y_q[i] <= sum_y_d[i];
          end
        end
      end

      out_valid_q <= res_valid_q;
      if (res_valid_q) begin
        x_q   <= x_d;
        y_q   <= y_d;
        sat_q <= sat_d;
      end
    end
  end

  assign x_out     = x_q;
  assign y_out     = y_q;
  assign sat       = sat_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_multi_ch_lockin.sv
// Self-checking bench for multi_ch_lockin: a reference model pushes expected dumps (with
// their due cycle) into a scoreboard as samples are driven; each out_valid pops one entry.
module tb_multi_ch_lockin;

  localparam int N_CH  = 2;
  localparam int SIG_W = 14;
  localparam int REF_W = 16;
  localparam int OUT_W = 24;
  localparam int ACC_W = 56;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic                  in_valid = 1'b0;
  logic [N_CH*SIG_W-1:0] signal_in = '0;
  logic [REF_W-1:0]      ref_sin = '0;
  logic [REF_W-1:0]      ref_cos = '0;
  logic [31:0]           period_len = 32'd4;
  logic [5:0]            shift = 6'd4;
  logic                  clear = 1'b0;
  logic [N_CH*OUT_W-1:0] x_out, y_out;
  logic                  out_valid;
  logic [2*N_CH-1:0]     sat;

  multi_ch_lockin #(.N_CH(N_CH), .SIG_W(SIG_W), .REF_W(REF_W), .OUT_W(OUT_W), .ACC_W(ACC_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .signal_in(signal_in),
    .ref_sin(ref_sin), .ref_cos(ref_cos), .period_len(period_len), .shift(shift),
    .clear(clear), .x_out(x_out), .y_out(y_out), .out_valid(out_valid), .sat(sat)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [OUT_W-1:0] x0, x1, y0, y1;
    logic [3:0]       sat;
    int               due;
  } exp_t;

  exp_t   sb[$];
  exp_t   last_e;
  int     n_cmp = 0;
  int     n_bad = 0;
  int     n_pulse = 0;

  int          m_cnt = 0;
  int unsigned m_per = 1;
  longint      ax[2] = '{0, 0};
  longint      ay[2] = '{0, 0};

  function automatic void scale(input longint a, input logic [5:0] sh,
                                output logic [OUT_W-1:0] r, output logic s);
    longint v;
    v = a >>> sh;
    if (v > 64'sd8388607)       begin r = 24'h7fffff; s = 1'b1; end
    else if (v < -64'sd8388608) begin r = 24'h800000; s = 1'b1; end
    else                        begin r = v[OUT_W-1:0]; s = 1'b0; end
  endfunction

  task automatic model_reset();
    m_cnt = 0;
    ax = '{0, 0};
    ay = '{0, 0};
  endtask

  // One clock: drive inputs, advance the model, then observe #1 after the edge.
  task automatic step(input int s0, input int s1, input int sn, input int cs,
                      input logic v, input logic clr);
    exp_t e;
    exp_t g;
    logic sx0, sx1, sy0, sy1;
    signal_in = {SIG_W'(s1), SIG_W'(s0)};
    ref_sin   = REF_W'(sn);
    ref_cos   = REF_W'(cs);
    in_valid  = v;
    clear     = clr;
    if (clr) begin
      model_reset();
    end else if (v) begin
      if (m_cnt == 0) m_per = (period_len == 0) ? 1 : period_len;
      ax[0] += longint'(s0) * longint'(sn);
      ax[1] += longint'(s1) * longint'(sn);
      ay[0] += longint'(s0) * longint'(cs);
      ay[1] += longint'(s1) * longint'(cs);
      if (m_cnt == int'(m_per) - 1) begin
        scale(ax[0], shift, e.x0, sx0);
        scale(ax[1], shift, e.x1, sx1);
        scale(ay[0], shift, e.y0, sy0);
        scale(ay[1], shift, e.y1, sy1);
        e.sat = {sy1, sx1, sy0, sx0};
        e.due = cyc + 4;
        sb.push_back(e);
        model_reset();
      end else begin
        m_cnt++;
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    clear    = 1'b0;
    if (out_valid === 1'b1) begin
      n_pulse++;
      n_cmp++;
      if (sb.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_out_valid: out_valid=1 at cycle %0d, required no pulse", cyc);
      end else begin
        g = sb.pop_front();
        last_e = g;
        if ({x_out, y_out} !== {g.x1, g.x0, g.y1, g.y0}) begin
          n_bad++;
          $display("FAIL dump_values: got x1=%0d x0=%0d y1=%0d y0=%0d, required x1=%0d x0=%0d y1=%0d y0=%0d",
                   $signed(x_out[47:24]), $signed(x_out[23:0]), $signed(y_out[47:24]), $signed(y_out[23:0]),
                   $signed(g.x1), $signed(g.x0), $signed(g.y1), $signed(g.y0));
        end
        n_cmp++;
        if (sat !== g.sat) begin
          n_bad++;
          $display("FAIL dump_sat: got %b, required %b", sat, g.sat);
        end
        n_cmp++;
        if (cyc !== g.due) begin
          n_bad++;
          $display("FAIL dump_timing: pulse at cycle %0d, required cycle %0d", cyc, g.due);
        end
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 1'b0, 1'b0);
  endtask

  // Bounded wait for all pending dumps, then a few quiet cycles to catch stray pulses.
  task automatic drain();
    int budget;
    budget = 0;
    while (sb.size() != 0 && budget < 30) begin
      idle(1);
      budget++;
    end
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL drain_timeout: %0d dumps still pending, required 0", sb.size());
      sb.delete();
    end
    idle(4);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if ({x_out, y_out, sat, out_valid} !== '0) begin
      n_bad++;
      $display("FAIL reset_state: got x=%h y=%h sat=%b ov=%b, required all 0", x_out, y_out, sat, out_valid);
    end
    rst = 1'b0;
    model_reset();
    idle(2);
  endtask

  task automatic test_basic();
    int p0;
    period_len = 4;
    shift = 4;
    p0 = n_pulse;
    for (int i = 0; i < 12; i++) step(1000, -1000, 16384, 0, 1'b1, 1'b0);
    drain();
    n_cmp++;
    if (n_pulse - p0 !== 3) begin
      n_bad++;
      $display("FAIL basic_pulse_count: got %0d, required 3", n_pulse - p0);
    end
  endtask

  task automatic test_saturation();
    int p0;
    shift = 0;
    p0 = n_pulse;
    for (int i = 0; i < 8; i++) step(1000, -1000, 16384, 0, 1'b1, 1'b0);
    drain();
    n_cmp++;
    if (n_pulse - p0 !== 2) begin
      n_bad++;
      $display("FAIL sat_pulse_count: got %0d, required 2", n_pulse - p0);
    end
    n_cmp++;
    if (sat !== 4'b0101) begin
      n_bad++;
      $display("FAIL sat_flags_hold: got %b, required 0101", sat);
    end
  endtask

  task automatic test_period_zero();
    int p0;
    period_len = 0;
    shift = 0;
    p0 = n_pulse;
    for (int i = 0; i < 5; i++) step(3, -7, 2, -5, 1'b1, 1'b0);
    drain();
    n_cmp++;
    if (n_pulse - p0 !== 5) begin
      n_bad++;
      $display("FAIL period0_pulse_count: got %0d, required 5", n_pulse - p0);
    end
    n_cmp++;
    if ({x_out[23:0], y_out[23:0]} !== {24'd6, -24'sd15}) begin
      n_bad++;
      $display("FAIL period0_values: got x0=%0d y0=%0d, required x0=6 y0=-15",
               $signed(x_out[23:0]), $signed(y_out[23:0]));
    end
  endtask

  task automatic test_gaps();
    int p0;
    period_len = 4;
    shift = 4;
    p0 = n_pulse;
    for (int i = 0; i < 8; i++) begin
      step(1000, -1000, 16384, 0, 1'b1, 1'b0);
      step(0, 0, 0, 0, 1'b0, 1'b0);
    end
    drain();
    n_cmp++;
    if (n_pulse - p0 !== 2) begin
      n_bad++;
      $display("FAIL gaps_pulse_count: got %0d, required 2", n_pulse - p0);
    end
  endtask

  task automatic test_period_change();
    int p0;
    period_len = 4;
    shift = 0;
    p0 = n_pulse;
    for (int i = 0; i < 8; i++) begin
      if (i == 2) period_len = 2;
      step(100 * (i + 1), -50 * (i + 1), 300, 200, 1'b1, 1'b0);
    end
    drain();
    n_cmp++;
    if (n_pulse - p0 !== 3) begin
      n_bad++;
      $display("FAIL period_change_pulse_count: got %0d, required 3", n_pulse - p0);
    end
  endtask

  task automatic test_clear();
    int p0;
    period_len = 4;
    shift = 4;
    p0 = n_pulse;
    step(1000, -1000, 16384, 4096, 1'b1, 1'b0);
    step(1000, -1000, 16384, 4096, 1'b1, 1'b0);
    step(1000, -1000, 16384, 4096, 1'b1, 1'b1);
    idle(5);
    n_cmp++;
    if ({x_out, y_out} !== {last_e.x1, last_e.x0, last_e.y1, last_e.y0}) begin
      n_bad++;
      $display("FAIL clear_hold: got x=%h y=%h, required x=%h%h y=%h%h",
               x_out, y_out, last_e.x1, last_e.x0, last_e.y1, last_e.y0);
    end
    for (int i = 0; i < 4; i++) step(500, 250, 16384, -8192, 1'b1, 1'b0);
    drain();
    n_cmp++;
    if (n_pulse - p0 !== 1) begin
      n_bad++;
      $display("FAIL clear_pulse_count: got %0d, required 1", n_pulse - p0);
    end
  endtask

  task automatic test_async_reset();
    int p0;
    period_len = 4;
    shift = 4;
    step(700, -300, 16384, 1000, 1'b1, 1'b0);
    step(700, -300, 16384, 1000, 1'b1, 1'b0);
    #3;
    rst = 1'b1;
    #1;
    n_cmp++;
    if ({x_out, y_out, sat, out_valid} !== '0) begin
      n_bad++;
      $display("FAIL async_reset: got x=%h y=%h sat=%b ov=%b, required all 0", x_out, y_out, sat, out_valid);
    end
    model_reset();
    sb.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    p0 = n_pulse;
    idle(1);
    for (int i = 0; i < 4; i++) step(-200, 900, 12000, -16000, 1'b1, 1'b0);
    drain();
    n_cmp++;
    if (n_pulse - p0 !== 1) begin
      n_bad++;
      $display("FAIL reset_restart_pulse_count: got %0d, required 1", n_pulse - p0);
    end
  endtask

  initial begin
    last_e = '{x0: '0, x1: '0, y0: '0, y1: '0, sat: '0, due: 0};
    #1;
    test_reset();
    test_basic();
    test_saturation();
    test_period_zero();
    test_gaps();
    test_period_change();
    test_clear();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
